// File: rtl/qed_dup_scheduler.sv
// rtl/qed_dup_scheduler.sv - SQED scheduler: issues originals, buffers them, replays them as duplicates
// Two-state ORIG/DUP controller with an original-instruction FIFO and saturating issue counters.
module qed_dup_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_x,
  input  logic             ena,
  input  logic             exec_dup,
  input  logic             stall,
  input  logic [31:0]      ifu_instruction,
  input  logic             ifu_valid,
  output logic             ifu_ready,
  output logic [31:0]      qed_instruction,
  output logic             qed_valid,
  output logic             qed_mode,
  output logic [CNT_W-1:0] num_orig,
  output logic [CNT_W-1:0] num_dup,
  output logic             qed_ready
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_NOP = 7'b1111111;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {ORIG = 1'b0, DUP = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [CNT_W-1:0]    num_orig_q, num_orig_d, num_dup_q, num_dup_d;
  logic [31:0]         qed_instr_q, qed_instr_d;
  logic                qed_valid_q, qed_valid_d;
  logic                qed_ready_q, qed_ready_d;
  logic                push, pop, fifo_empty, fifo_full, do_switch;

  // Originals touch only x0-x15 and the lower 1 KiB, so setting bit 4 / imm bit 10 remaps them.
  function automatic logic [31:0] dup_xform(input logic [31:0] ins);
    logic [31:0] d;
    d = ins;
    case (ins[6:0])
      OP_R:    begin d[11] = 1'b1; d[19] = 1'b1; d[24] = 1'b1; end
      OP_I:    begin d[11] = 1'b1; d[19] = 1'b1; end
      OP_LW:   begin d[11] = 1'b1; d[30] = 1'b1; end
      OP_SW:   begin d[24] = 1'b1; d[30] = 1'b1; end
      default: d = ins;
    endcase
    return d;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    num_orig_d  = num_orig_q;
    num_dup_d   = num_dup_q;
    qed_instr_d = qed_instr_q;
    qed_valid_d = qed_valid_q;
    ifu_ready   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    do_switch   = 1'b0;

    if (state_q == ORIG && !ena) begin
      ifu_ready = !stall;
      if (!stall) begin
        qed_instr_d = ifu_instruction;
        qed_valid_d = ifu_valid;
      end
    end else if (state_q == ORIG) begin
      do_switch = !stall && !fifo_empty && (exec_dup || fifo_full);
      ifu_ready = !stall && !fifo_full && !do_switch;
      if (!stall) begin
        qed_valid_d = 1'b0;
        if (do_switch) begin
          state_d = DUP;
        end else if (ifu_valid && ifu_ready) begin
          qed_instr_d = ifu_instruction;
          qed_valid_d = 1'b1;
          if (ifu_instruction[6:0] != OP_NOP) begin
            push = 1'b1;
            if (num_orig_q != '1) num_orig_d = num_orig_q + CNT_W'(1);
          end
        end
      end
    end else begin
      // DUP keeps draining even if ena drops; bypass resumes once back in ORIG.
      if (!stall) begin
        pop         = 1'b1;
        qed_instr_d = dup_xform(mem_q[rd_ptr_q]);
        qed_valid_d = 1'b1;
        if (num_dup_q != '1) num_dup_d = num_dup_q + CNT_W'(1);
        if (count_q == (ADDR_W + 1)'(1)) state_d = ORIG;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      count_d  = count_q + (ADDR_W + 1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d  = count_q - (ADDR_W + 1)'(1);
    end

    qed_ready_d = (state_d == ORIG) && (count_d == '0) &&
                  (num_orig_d == num_dup_d) && (num_orig_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      state_q     <= ORIG;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      num_orig_q  <= '0;
      num_dup_q   <= '0;
      qed_instr_q <= 32'h0000007F;
      qed_valid_q <= 1'b0;
      qed_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      num_orig_q  <= num_orig_d;
      num_dup_q   <= num_dup_d;
      qed_instr_q <= qed_instr_d;
      qed_valid_q <= qed_valid_d;
      qed_ready_q <= qed_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ifu_instruction;
  end

  assign qed_instruction = qed_instr_q;
  assign qed_valid       = qed_valid_q;
  assign qed_mode        = (state_q == DUP);
  assign num_orig        = num_orig_q;
  assign num_dup         = num_dup_q;
  assign qed_ready       = qed_ready_q;

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// tb/tb_qed_dup_scheduler.sv - self-checking bench for qed_dup_scheduler
// Reference model: queue of pending originals, mode bit and issue counts.
module tb_qed_dup_scheduler;
  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h0000007F;

  logic        clk = 1'b0;
  logic        reset_x, ena, exec_dup, stall, ifu_valid;
  logic [31:0] ifu_instruction;
  logic        ifu_ready, qed_valid, qed_mode, qed_ready;
  logic [31:0] qed_instruction;
  logic [15:0] num_orig, num_dup;

  qed_dup_scheduler #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset_x(reset_x), .ena(ena), .exec_dup(exec_dup), .stall(stall),
    .ifu_instruction(ifu_instruction), .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
    .qed_instruction(qed_instruction), .qed_valid(qed_valid), .qed_mode(qed_mode),
    .num_orig(num_orig), .num_dup(num_dup), .qed_ready(qed_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit          m_mode, m_valid, m_qready;
  logic [31:0] m_instr;
  logic [31:0] m_q[$];
  int          m_norig, m_ndup;
  bit          obs_ready, exp_ready;

  // Duplicate built from decoded fields: registers +16, memory offset +1024.
  function automatic logic [31:0] dup_of(input logic [31:0] i);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    rd = i[11:7]; rs1 = i[19:15]; rs2 = i[24:20];
    case (i[6:0])
      7'b0110011: return {i[31:25], rs2 + 5'd16, rs1 + 5'd16, i[14:12], rd + 5'd16, i[6:0]};
      7'b0010011: return {i[31:20], rs1 + 5'd16, i[14:12], rd + 5'd16, i[6:0]};
      7'b0000011: begin
        imm = i[31:20] + 12'd1024;
        return {imm, rs1, i[14:12], rd + 5'd16, i[6:0]};
      end
      7'b0100011: begin
        imm = {i[31:25], i[11:7]} + 12'd1024;
        return {imm[11:5], rs2 + 5'd16, rs1, i[14:12], imm[4:0], i[6:0]};
      end
      default: return i;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr(input bit alu_only);
    logic [3:0]  rd, r1, r2;
    logic [11:0] imm;
    logic [9:0]  off;
    int k;
    rd  = 4'($urandom_range(0, 15));
    r1  = 4'($urandom_range(0, 15));
    r2  = 4'($urandom_range(0, 15));
    imm = 12'($urandom_range(0, 4095));
    off = 10'($urandom_range(0, 255) * 4);
    k   = alu_only ? $urandom_range(0, 1) : $urandom_range(0, 4);
    case (k)
      0: return {7'h00, 1'b0, r2, 1'b0, r1, 3'b000, 1'b0, rd, 7'b0110011};
      1: return {imm, 1'b0, r1, 3'b000, 1'b0, rd, 7'b0010011};
      2: return {2'b00, off, 5'd0, 3'b010, 1'b0, rd, 7'b0000011};
      3: return {2'b00, off[9:5], 1'b0, r2, 5'd0, 3'b010, off[4:0], 7'b0100011};
      default: return NOP;
    endcase
  endfunction

  function automatic bit m_ready(input bit ed, input bit st, input bit en);
    if (m_mode) return 1'b0;
    if (!en) return !st;
    if (st) return 1'b0;
    if (m_q.size() == DEPTH) return 1'b0;
    if (ed && m_q.size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_step(input bit v, input logic [31:0] ins, input bit ed, input bit st,
                        input bit en, input bit rdy);
    if (st) return;
    if (!m_mode && !en) begin
      m_instr = ins;
      m_valid = v;
    end else if (!m_mode) begin
      if (m_q.size() != 0 && (ed || m_q.size() == DEPTH)) begin
        m_mode  = 1'b1;
        m_valid = 1'b0;
      end else if (v && rdy) begin
        m_instr = ins;
        m_valid = 1'b1;
        if (ins[6:0] != 7'h7F) begin
          m_q.push_back(ins);
          if (m_norig < 65535) m_norig++;
        end
      end else begin
        m_valid = 1'b0;
      end
    end else begin
      m_instr = dup_of(m_q.pop_front());
      m_valid = 1'b1;
      if (m_ndup < 65535) m_ndup++;
      if (m_q.size() == 0) m_mode = 1'b0;
    end
    m_qready = !m_mode && m_q.size() == 0 && m_norig == m_ndup && m_norig != 0;
  endtask

  function automatic logic [67:0] got_vec();
    return {qed_instruction, qed_valid, qed_mode, num_orig, num_dup, qed_ready, obs_ready};
  endfunction

  function automatic logic [67:0] want_vec();
    return {m_instr, m_valid, m_mode, 16'(m_norig), 16'(m_ndup), m_qready, exp_ready};
  endfunction

  task automatic do_reset();
    reset_x = 1'b0; ena = 1'b1; exec_dup = 1'b0; stall = 1'b0;
    ifu_valid = 1'b0; ifu_instruction = '0;
    @(posedge clk); #1;
    reset_x = 1'b1;
    m_mode = 0; m_valid = 0; m_qready = 0; m_instr = NOP;
    m_q.delete(); m_norig = 0; m_ndup = 0;
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins, input bit ed, input bit st, input bit en);
    ifu_valid = v; ifu_instruction = ins; exec_dup = ed; stall = st; ena = en;
    #2;
    obs_ready = ifu_ready;
    exp_ready = m_ready(ed, st, en);
    @(posedge clk); #1;
    m_step(v, ins, ed, st, en, exp_ready);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({qed_instruction, qed_valid, qed_mode, num_orig, num_dup, qed_ready} !==
        {32'h0000007F, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_values: got %h %b %b %0d %0d %b", qed_instruction, qed_valid,
               qed_mode, num_orig, num_dup, qed_ready);
    end
    n_checks++;
    if (ifu_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ifu_ready: got %b expected 1", ifu_ready);
    end
  endtask

  task automatic test_add_dup();
    do_reset();
    cyc(1, 32'h003100B3, 0, 0, 1);
    n_checks++;
    if ({qed_instruction, qed_valid} !== {32'h003100B3, 1'b1}) begin
      n_errors++;
      $display("FAIL add_orig: got %h/%b expected 003100b3/1", qed_instruction, qed_valid);
    end
    cyc(0, 0, 1, 0, 1);
    n_checks++;
    if ({qed_mode, qed_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL add_switch: mode/valid got %b%b expected 10", qed_mode, qed_valid);
    end
    cyc(0, 0, 0, 0, 1);
    n_checks++;
    if ({qed_instruction, qed_valid, qed_mode, num_orig, num_dup, qed_ready} !==
        {32'h013908B3, 1'b1, 1'b0, 16'd1, 16'd1, 1'b1}) begin
      n_errors++;
      $display("FAIL add_dup: got %h v%b m%b %0d %0d r%b expected 013908b3 v1 m0 1 1 r1",
               qed_instruction, qed_valid, qed_mode, num_orig, num_dup, qed_ready);
    end
  endtask

  task automatic test_lw_sw();
    do_reset();
    cyc(1, 32'h00802283, 0, 0, 1);
    cyc(1, 32'h00502623, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    n_checks++;
    if ({qed_instruction, qed_ready} !== {32'h40802A83, 1'b0}) begin
      n_errors++;
      $display("FAIL lw_dup: got %h r%b expected 40802a83 r0", qed_instruction, qed_ready);
    end
    cyc(0, 0, 0, 0, 1);
    n_checks++;
    if ({qed_instruction, qed_ready, num_orig, num_dup} !== {32'h41502623, 1'b1, 16'd2, 16'd2}) begin
      n_errors++;
      $display("FAIL sw_dup: got %h r%b %0d %0d expected 41502623 r1 2 2",
               qed_instruction, qed_ready, num_orig, num_dup);
    end
  endtask

  task automatic test_full_wrap();
    int sizes[3] = '{8, 5, 8};
    do_reset();
    foreach (sizes[b]) begin
      for (int i = 0; i < sizes[b]; i++) begin
        cyc(1, rand_instr(1), 0, 0, 1);
        n_checks++;
        if (got_vec() !== want_vec()) begin
          n_errors++;
          $display("FAIL full_fill b%0d i%0d: got %h expected %h", b, i, got_vec(), want_vec());
        end
      end
      cyc(1, rand_instr(1), sizes[b] != DEPTH, 0, 1);
      n_checks++;
      if ({obs_ready, qed_mode} !== 2'b01) begin
        n_errors++;
        $display("FAIL full_switch b%0d: ready/mode got %b%b expected 01", b, obs_ready, qed_mode);
      end
      for (int i = 0; i < sizes[b]; i++) begin
        cyc(1, rand_instr(1), 0, 0, 1);
        n_checks++;
        if (got_vec() !== want_vec()) begin
          n_errors++;
          $display("FAIL full_replay b%0d i%0d: got %h expected %h", b, i, got_vec(), want_vec());
        end
      end
    end
    n_checks++;
    if ({num_orig, num_dup, qed_ready} !== {16'd21, 16'd21, 1'b1}) begin
      n_errors++;
      $display("FAIL full_counts: got %0d %0d r%b expected 21 21 r1", num_orig, num_dup, qed_ready);
    end
  endtask

  task automatic test_nop();
    do_reset();
    cyc(1, NOP, 1, 0, 1);
    n_checks++;
    if ({qed_instruction, qed_valid, qed_mode, num_orig} !== {NOP, 1'b1, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL nop_issue: got %h v%b m%b %0d expected 0000007f v1 m0 0",
               qed_instruction, qed_valid, qed_mode, num_orig);
    end
    cyc(1, 32'h003100B3, 1, 0, 1);
    n_checks++;
    if ({obs_ready, qed_mode, qed_instruction, num_orig} !== {1'b1, 1'b0, 32'h003100B3, 16'd1}) begin
      n_errors++;
      $display("FAIL nop_empty_exec_dup: got r%b m%b %h %0d expected r1 m0 003100b3 1",
               obs_ready, qed_mode, qed_instruction, num_orig);
    end
    cyc(1, NOP, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    n_checks++;
    if ({qed_instruction, qed_mode, num_dup, qed_ready} !== {32'h013908B3, 1'b0, 16'd1, 1'b1}) begin
      n_errors++;
      $display("FAIL nop_replay: got %h m%b %0d r%b expected 013908b3 m0 1 r1",
               qed_instruction, qed_mode, num_dup, qed_ready);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, rand_instr(0), 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    held = qed_instruction;
    for (int i = 0; i < 3; i++) begin
      cyc(1, rand_instr(0), $urandom_range(0, 1), 1, 1);
      n_checks++;
      if ({qed_instruction, qed_valid, qed_mode, obs_ready} !== {held, 1'b1, 1'b1, 1'b0} ||
          got_vec() !== want_vec()) begin
        n_errors++;
        $display("FAIL stall_freeze %0d: got %h expected %h held %h", i, got_vec(), want_vec(), held);
      end
    end
    while (m_mode) begin
      cyc(0, 0, 0, 0, 1);
      n_checks++;
      if (got_vec() !== want_vec()) begin
        n_errors++;
        $display("FAIL stall_resume: got %h expected %h", got_vec(), want_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, rand_instr(1), 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    do_reset();
    n_checks++;
    if ({qed_instruction, qed_valid, qed_mode, num_orig, num_dup, qed_ready} !==
        {32'h0000007F, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_mid: got %h v%b m%b %0d %0d r%b", qed_instruction, qed_valid,
               qed_mode, num_orig, num_dup, qed_ready);
    end
    cyc(1, 32'h00802283, 1, 0, 1);
    n_checks++;
    if ({obs_ready, qed_mode, qed_instruction, num_orig} !== {1'b1, 1'b0, 32'h00802283, 16'd1}) begin
      n_errors++;
      $display("FAIL reset_mid_empty: got r%b m%b %h %0d expected r1 m0 00802283 1",
               obs_ready, qed_mode, qed_instruction, num_orig);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc($urandom_range(0, 1), rand_instr(0), $urandom_range(0, 1), $urandom_range(0, 3) == 0, 0);
      n_checks++;
      if (got_vec() !== want_vec()) begin
        n_errors++;
        $display("FAIL bypass %0d: got %h expected %h", i, got_vec(), want_vec());
      end
    end
    for (int i = 0; i < 3; i++) cyc(1, rand_instr(1), 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, rand_instr(0), 0, 0, 0);
      n_checks++;
      if (got_vec() !== want_vec()) begin
        n_errors++;
        $display("FAIL bypass_drain %0d: got %h expected %h", i, got_vec(), want_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, rand_instr(0), $urandom_range(0, 9) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 15) != 0);
      n_checks++;
      if (got_vec() !== want_vec()) begin
        n_errors++;
        $display("FAIL random %0d: got %h expected %h", i, got_vec(), want_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_dup();
    test_lw_sw();
    test_full_wrap();
    test_nop();
    test_stall();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
